// File: rtl/m_stage.sv
// MIPS memory stage: E->M pipeline register plus data-memory port drive,
// store lane replication, load extension and address-exception detection.
module m_stage #(
  parameter logic [31:0] DM_BASE  = 32'h0000_0000,
  parameter logic [31:0] DM_LIMIT = 32'h0000_2FFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        flush,
  input  logic        exc_req,
  input  logic [31:0] E_pc,
  input  logic        E_regwe,
  input  logic [4:0]  E_A3,
  input  logic [31:0] E_aluout,
  input  logic [31:0] E_rtdata,
  input  logic [1:0]  E_Tnew,
  input  logic [4:0]  E_rtad,
  input  logic        E_bd,
  input  logic [3:0]  E_memop,
  input  logic [4:0]  E_excode,
  input  logic [31:0] m_data_rdata,
  output logic [31:0] m_data_addr,
  output logic [31:0] m_data_wdata,
  output logic [3:0]  m_data_byteen,
  output logic [31:0] M_pc,
  output logic        M_regwe,
  output logic [4:0]  M_A3,
  output logic [31:0] M_regwd,
  output logic [1:0]  M_Tnew,
  output logic [4:0]  M_rtad,
  output logic        M_bd,
  output logic [4:0]  M_excode
);

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LW   = 4'd1,
    MEM_LH   = 4'd2,
    MEM_LHU  = 4'd3,
    MEM_LB   = 4'd4,
    MEM_LBU  = 4'd5,
    MEM_SW   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SB   = 4'd8
  } memop_e;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  typedef struct packed {
    logic [31:0] pc;
    logic        regwe;
    logic [4:0]  a3;
    logic [31:0] aluout;
    logic [31:0] rtdata;
    logic [1:0]  tnew;
    logic [4:0]  rtad;
    logic        bd;
    logic [3:0]  memop;
    logic [4:0]  excode;
  } pipe_t;

  pipe_t pipe_q, pipe_d;

  logic       e_load, e_store, e_misalign, e_range_bad;
  logic [4:0] e_local_code;

  // Address-exception code for the instruction entering from E.
  // NOTE: every signal written in an always_comb gets a value on every path
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    e_load      = (E_memop >= MEM_LW) && (E_memop <= MEM_LBU);
    e_store     = (E_memop >= MEM_SW) && (E_memop <= MEM_SB);
    e_misalign  = 1'b0;
    case (E_memop)
      MEM_LW, MEM_SW:          e_misalign = (E_aluout[1:0] != 2'b00);
      MEM_LH, MEM_LHU, MEM_SH: e_misalign = E_aluout[0];
      default:                 e_misalign = 1'b0;
    endcase
    // Offset form covers both bounds without a constant-zero comparison.
    e_range_bad = (E_aluout - DM_BASE) > (DM_LIMIT - DM_BASE);
    e_local_code = 5'd0;
    if (e_misalign || e_range_bad) begin
      if (e_load)       e_local_code = EXC_ADEL;
      else if (e_store) e_local_code = EXC_ADES;
    end
  end

  always_comb begin
    pipe_d = pipe_q;
    if (flush) begin
      pipe_d    = '0;
      pipe_d.pc = E_pc;
      pipe_d.bd = E_bd;
    end else if (en) begin
      pipe_d.pc     = E_pc;
      pipe_d.regwe  = E_regwe;
      pipe_d.a3     = E_A3;
      pipe_d.aluout = E_aluout;
      pipe_d.rtdata = E_rtdata;
      pipe_d.tnew   = (E_Tnew != 2'd0) ? E_Tnew - 2'd1 : 2'd0;
      pipe_d.rtad   = E_rtad;
      pipe_d.bd     = E_bd;
      pipe_d.memop  = E_memop;
      pipe_d.excode = (E_excode != 5'd0) ? E_excode : e_local_code;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of its inputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pipe_q <= '0;
    else        pipe_q <= pipe_d;
  end

  logic        m_load;
  logic [15:0] ld_half;
  logic [7:0]  ld_byte;
  logic [3:0]  byteen_raw;

  always_comb begin
    m_load = (pipe_q.memop >= MEM_LW) && (pipe_q.memop <= MEM_LBU);

    byteen_raw   = 4'b0000;
    m_data_wdata = pipe_q.rtdata;
    case (pipe_q.memop)
      MEM_SW: byteen_raw = 4'b1111;
      MEM_SH: begin
        byteen_raw   = pipe_q.aluout[1] ? 4'b1100 : 4'b0011;
        m_data_wdata = {2{pipe_q.rtdata[15:0]}};
      end
      MEM_SB: begin
        byteen_raw   = 4'b0001 << pipe_q.aluout[1:0];
        m_data_wdata = {4{pipe_q.rtdata[7:0]}};
      end
      default: ;
    endcase
    m_data_byteen = (exc_req || pipe_q.excode != 5'd0) ? 4'b0000 : byteen_raw;

    ld_half = pipe_q.aluout[1] ? m_data_rdata[31:16] : m_data_rdata[15:0];
    case (pipe_q.aluout[1:0])
      2'd0:    ld_byte = m_data_rdata[7:0];
      2'd1:    ld_byte = m_data_rdata[15:8];
      2'd2:    ld_byte = m_data_rdata[23:16];
      default: ld_byte = m_data_rdata[31:24];
    endcase

    case (pipe_q.memop)
      MEM_LW:  M_regwd = m_data_rdata;
      MEM_LH:  M_regwd = {{16{ld_half[15]}}, ld_half};
      MEM_LHU: M_regwd = {16'd0, ld_half};
      MEM_LB:  M_regwd = {{24{ld_byte[7]}}, ld_byte};
      MEM_LBU: M_regwd = {24'd0, ld_byte};
      default: M_regwd = pipe_q.aluout;
    endcase
  end

  // A faulting load must not write back garbage.
  assign M_regwe     = pipe_q.regwe && !(m_load && pipe_q.excode != 5'd0);
  assign m_data_addr = pipe_q.aluout;
  assign M_pc        = pipe_q.pc;
  assign M_A3        = pipe_q.a3;
  assign M_Tnew      = pipe_q.tnew;
  assign M_rtad      = pipe_q.rtad;
  assign M_bd        = pipe_q.bd;
  assign M_excode    = pipe_q.excode;

endmodule
